// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - shared types and constants for the program image loader
package prog_loader_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN  = 3'd1,
        DATA = 3'd2,
        CSUM = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } loader_state_t;

    localparam int          LDR_BYTE_W  = 8;
    localparam logic [7:0]  LDR_CSUM_OK = 8'h00;

endpackage

// File: rtl/prog_loader_xor_csum8.sv
// rtl/prog_loader_xor_csum8.sv - byte-wide running XOR checksum accumulator
module xor_csum8
    import prog_loader_pkg::*;
(
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  clr,
    input  logic                  en,
    input  logic [LDR_BYTE_W-1:0] din,
    output logic [LDR_BYTE_W-1:0] acc
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc ^ din;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - parses a framed host image and writes it into program memory
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int DATA_SIZE = 6,
    parameter int ADDR_SIZE = 5
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  mem_w,
    output logic [ADDR_SIZE-1:0]  mem_addr,
    output logic [DATA_SIZE-1:0]  mem_data,
    output logic                  busy,
    output logic                  cpu_run,
    output logic                  err
);

    localparam int             CAP = 2 ** ADDR_SIZE;
    localparam logic [ADDR_SIZE:0] ONE = 1;

    loader_state_t state, state_nxt;

    logic [ADDR_SIZE:0]    cnt;
    logic [ADDR_SIZE:0]    n_words;
    logic [LDR_BYTE_W-1:0] acc;

    logic xfer;
    logic start_ok;
    logic len_bad;
    logic len_fire;
    logic wr_fire;
    logic last_word;
    logic csum_good;

    assign busy     = (state == LEN) || (state == DATA) || (state == CSUM);
    assign in_ready = busy;
    assign cpu_run  = (state == DONE);
    assign err      = (state == ERR);

    // abort wins over everything, so it also masks any transfer in its cycle
    assign xfer      = in_valid && busy && !abort;
    assign start_ok  = start && !abort && ((state == IDLE) || (state == DONE) || (state == ERR));
    assign len_bad   = (in_data == 8'h00) || ({24'h0, in_data} > 32'(CAP));
    assign len_fire  = xfer && (state == LEN) && !len_bad;
    assign wr_fire   = xfer && (state == DATA);
    assign last_word = ((cnt + ONE) == n_words);
    assign csum_good = ((acc ^ in_data) == LDR_CSUM_OK);

    xor_csum8 u_csum (
        .clk  (clk),
        .rstn (rstn),
        .clr  (start_ok),
        .en   (xfer),
        .din  (in_data),
        .acc  (acc)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (start) state_nxt = LEN;
                LEN:  if (xfer)  state_nxt = len_bad ? ERR : DATA;
                DATA: if (xfer && last_word) state_nxt = CSUM;
                CSUM: if (xfer)  state_nxt = csum_good ? DONE : ERR;
                DONE: if (start) state_nxt = LEN;
                ERR:  if (start) state_nxt = LEN;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Word counter is one bit wider than the address so N = capacity ends without wrapping
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt      <= '0;
            n_words  <= '0;
            mem_w    <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
        end else begin
            mem_w <= wr_fire;
            if (start_ok) begin
                cnt <= '0;
            end else if (wr_fire) begin
                cnt <= cnt + ONE;
            end
            if (len_fire) begin
                n_words <= (ADDR_SIZE + 1)'(in_data);
            end
            if (wr_fire) begin
                mem_addr <= cnt[ADDR_SIZE-1:0];
                mem_data <= in_data[DATA_SIZE-1:0];
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - directed self-checking bench for prog_loader
module tb_prog_loader;

    logic       clk;
    logic       rstn;
    logic       start;
    logic       abort;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       mem_w;
    logic [4:0] mem_addr;
    logic [5:0] mem_data;
    logic       busy;
    logic       cpu_run;
    logic       err;

    int checks = 0;
    int errors = 0;

    int wr_cnt = 0;
    int wa[$];
    int wd[$];
    int wcyc[$];
    int cyc = 0;
    logic [5:0] mem_model [0:31];

    prog_loader #(.DATA_SIZE(6), .ADDR_SIZE(5)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .start    (start),
        .abort    (abort),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .mem_w    (mem_w),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .busy     (busy),
        .cpu_run  (cpu_run),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc++;
        if (mem_w) begin
            wr_cnt++;
            wa.push_back(int'(mem_addr));
            wd.push_back(int'(mem_data));
            wcyc.push_back(cyc);
            mem_model[mem_addr] = mem_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        wr_cnt = 0;
        wa.delete();
        wd.delete();
        wcyc.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] c;
        rstn = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        for (int i = 0; i < 32; i++) mem_model[i] = 6'h00;
        idle(2);
        check("rst_busy",  busy, 0);
        check("rst_ready", in_ready, 0);
        check("rst_memw",  mem_w, 0);
        check("rst_addr",  mem_addr, 0);
        check("rst_data",  mem_data, 0);
        check("rst_run",   cpu_run, 0);
        check("rst_err",   err, 0);
        rstn = 1'b1;
        idle(1);

        // nominal: 03 11 22 3F, checksum 03^11^22^3F = 0F
        clear_log();
        pulse_start();
        check("nom_busy", busy, 1);
        check("nom_ready", in_ready, 1);
        send(8'h03);
        send(8'h11);
        check("nom_w0", mem_w, 1);
        check("nom_a0", mem_addr, 0);
        check("nom_d0", mem_data, 6'h11);
        send(8'h22);
        check("nom_a1", mem_addr, 1);
        check("nom_d1", mem_data, 6'h22);
        send(8'h3F);
        check("nom_a2", mem_addr, 2);
        check("nom_d2", mem_data, 6'h3F);
        send(8'h0F);
        check("nom_run", cpu_run, 1);
        check("nom_err", err, 0);
        check("nom_busy_end", busy, 0);
        check("nom_w_end", mem_w, 0);
        check("nom_wcnt", wr_cnt, 3);
        check("nom_b2b", (wcyc.size() == 3) ? (wcyc[2] - wcyc[0]) : -1, 2);
        send(8'h55);
        check("done_ignores", wr_cnt, 3);

        // bad checksum
        clear_log();
        pulse_start();
        check("bad_run_drop", cpu_run, 0);
        send(8'h03); send(8'h11); send(8'h22); send(8'h3F); send(8'h00);
        check("bad_err", err, 1);
        check("bad_run", cpu_run, 0);
        check("bad_wcnt", wr_cnt, 3);

        // illegal lengths
        clear_log();
        pulse_start();
        send(8'h00);
        check("n0_err", err, 1);
        pulse_start();
        send(8'h21);
        check("n21_err", err, 1);
        idle(2);
        check("nlen_wcnt", wr_cnt, 0);

        // full memory, gappy valid; XOR of 0..31 is 0 so checksum = 20
        clear_log();
        pulse_start();
        send(8'h20);
        for (int i = 0; i < 32; i++) begin
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
            send(8'(i));
        end
        check("full_busy", busy, 1);
        idle(1);
        send(8'h20);
        check("full_run", cpu_run, 1);
        check("full_wcnt", wr_cnt, 32);
        for (int i = 0; i < 32; i++) begin
            check($sformatf("full_a%0d", i), (i < wa.size()) ? wa[i] : -1, i);
            check($sformatf("full_d%0d", i), (i < wd.size()) ? wd[i] : -1, i);
        end

        // abort coincident with the third data byte
        clear_log();
        pulse_start();
        send(8'h04); send(8'h05); send(8'h06);
        in_valid = 1'b1; in_data = 8'h07; abort = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; abort = 1'b0;
        check("abt_busy", busy, 0);
        check("abt_run", cpu_run, 0);
        check("abt_err", err, 0);
        check("abt_memw", mem_w, 0);
        idle(2);
        check("abt_wcnt", wr_cnt, 2);
        check("abt_m2", mem_model[2], 6'h02);
        check("abt_m1", mem_model[1], 6'h06);

        // asynchronous reset mid-frame
        clear_log();
        pulse_start();
        send(8'h04); send(8'h2A); send(8'h15);
        check("rmf_memw_pre", mem_w, 1);
        #2 rstn = 1'b0;
        #1;
        check("rmf_busy", busy, 0);
        check("rmf_memw", mem_w, 0);
        check("rmf_addr", mem_addr, 0);
        check("rmf_data", mem_data, 0);
        check("rmf_run", cpu_run, 0);
        check("rmf_err", err, 0);
        @(negedge clk);
        rstn = 1'b1;
        idle(1);
        check("rmf_m1", mem_model[1], 6'h15);

        // reload from DONE
        pulse_start();
        send(8'h01); send(8'h2B); send(8'h2A);
        check("rl_run1", cpu_run, 1);
        clear_log();
        pulse_start();
        check("rl_drop", cpu_run, 0);
        check("rl_nowr", wr_cnt, 0);
        c = 8'h01 ^ 8'h3C;
        send(8'h01); send(8'h3C); send(c);
        check("rl_run2", cpu_run, 1);
        check("rl_wcnt", wr_cnt, 1);
        check("rl_m0", mem_model[0], 6'h3C);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
